gpu_rect_raster: RTL and testbench
==================================

# gpu_rect_raster

Parametrised rectangle rasteriser. It accepts two corner coordinates, a colour and a mode (solid fill or 1-pixel outline), then emits the covered pixels in row-major order as a valid/ready stream toward the framebuffer writer. It is the successor to the single-mode fill generator. New in this block: corner normalisation, screen clipping, outline mode, output backpressure, abort, and a one-cycle done pulse.

## Interface
Parameters:
- WIDTH_BITS, 10, x coordinate width
- HEIGHT_BITS, 9, y coordinate width
- SCREEN_W, 640, visible width; valid x is 0..SCREEN_W-1
- SCREEN_H, 480, visible height; valid y is 0..SCREEN_H-1
- CHANNEL_BITS, 8, colour channel width

Ports:
- clk  in  1  single clock; all logic on the rising edge
- n_rst  in  1  asynchronous, active-low reset
- start_i  in  1  level; sampled only in IDLE
- abort_i  in  1  cancels the command in progress
- x1_i, x2_i  in  WIDTH_BITS  corner x, any order
- y1_i, y2_i  in  HEIGHT_BITS  corner y, any order
- mode_i  in  1  0 = fill, 1 = outline
- r_i, g_i, b_i  in  CHANNEL_BITS  colour, latched at start
- x_o  out  WIDTH_BITS  pixel x
- y_o  out  HEIGHT_BITS  pixel y
- r_o, g_o, b_o  out  CHANNEL_BITS  latched colour
- valid_o  out  1  pixel on x_o/y_o is valid
- ready_i  in  1  consumer accepts the pixel
- busy_o  out  1  command in progress
- done_o  out  1  one-cycle completion pulse

## Operation
- States: IDLE, RUN, DONE.
- Reset: state IDLE; all outputs 0.
- Command accept, IDLE with start_i=1:
  - Latch xmin=min(x1,x2), xmax=max(x1,x2); same for y.
  - Clip: xmax=min(xmax,SCREEN_W-1), ymax=min(ymax,SCREEN_H-1).
  - Latch mode and colour; later changes on any input are ignored until the next start.
- Empty command: if xmin>SCREEN_W-1 or ymin>SCREEN_H-1, go directly to DONE. No valid_o is ever raised.
- Otherwise go to RUN with x_o=xmin, y_o=ymin, valid_o=1, busy_o=1.
- RUN stepping, on each handshake (valid_o & ready_i):
  - If (x,y)=(xmax,ymax): go to DONE.
  - Else if x=xmax: x=xmin, y=y+1.
  - Else, outline mode on an interior row (ymin<y<ymax): x jumps from xmin straight to xmax.
  - Else: x=x+1.
- Outline degenerate cases: a single row emits all pixels; a single column emits one pixel per row.
- Backpressure: while valid_o=1 and ready_i=0, x_o, y_o and colour hold stable.
- DONE: done_o=1, valid_o=0, busy_o=0 for exactly one cycle, then IDLE.
- abort_i=1 in RUN: next cycle is IDLE with valid_o=0 and busy_o=0, no done_o. abort_i has priority over a simultaneous handshake. abort_i in IDLE or DONE has no effect.
- start_i while in RUN or DONE is ignored; start is not re-armed by an edge.
- Asynchronous reset mid-command: immediately IDLE, outputs 0.
- Arithmetic: counters are the port widths. Clipped bounds cannot wrap, since xmax ≤ SCREEN_W-1 < 2^WIDTH_BITS.

## Timing
- start_i sampled at edge 0; first pixel valid after edge 1. Latency is 1 cycle.
- Throughput: 1 pixel per cycle while ready_i=1.
- Last handshake at cycle N means done_o is high during cycle N+1.
- Empty command: done_o high during cycle 1.
- Earliest next start is sampled in the IDLE cycle after DONE.
- All outputs are registered; there are no combinational input-to-output paths.

## Structure
- gpu_pkg holds:
  - state_t enum (IDLE/RUN/DONE)
  - mode constants MODE_FILL and MODE_OUTLINE
  - default SCREEN_W and SCREEN_H
- Sub-module gpu_rect_clip is combinational: it normalises and clips the corners and produces xmin/xmax/ymin/ymax plus an empty flag.
- The top-level block holds the FSM, the x/y counters and the output registers.

## Test plan
- Fill (2,3)-(4,4), ready_i=1: (2,3),(3,3),(4,3),(2,4),(3,4),(4,4) on cycles 1-6; done_o on cycle 7; busy_o low by cycle 7.
- Corners swapped, (4,4)-(2,3): identical sequence and timing.
- Outline (0,0)-(3,2): 10 pixels, (0,0)..(3,0),(0,1),(3,1),(0,2)..(3,2); single column (5,0)-(5,2) gives (5,0),(5,1),(5,2).
- Clip (630,470)-(700,500): 100 pixels, x 630..639 by y 470..479, last pixel (639,479). Off-screen (650,0)-(660,5): no valid_o, done_o on cycle 1.
- Backpressure: fill (0,0)-(3,0) with ready_i=0 on cycles 2-4: (1,0) held for 4 cycles with colour stable; 4 pixels total, each exactly once.
- Abort at cycle 3 of fill (0,0)-(9,9): valid_o=0 and busy_o=0 next cycle, no done_o; next start runs cleanly. Reset asserted mid-RUN: all outputs 0 at once.

Source files
------------

// File: rtl/gpu_pkg.sv
// Shared types and constants for the rectangle rasteriser: FSM encoding,
// draw-mode values and the default visible screen size.
package gpu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic MODE_FILL    = 1'b0;
    localparam logic MODE_OUTLINE = 1'b1;

    localparam int DEFAULT_SCREEN_W = 640;
    localparam int DEFAULT_SCREEN_H = 480;

endpackage

// File: rtl/gpu_rect_clip.sv
// Combinational corner normalisation and screen clipping. Produces ordered,
// clipped bounds plus a flag for rectangles that lie entirely off screen.
module gpu_rect_clip
    import gpu_pkg::*;
#(
    parameter int WIDTH_BITS  = 10,
    parameter int HEIGHT_BITS = 9,
    parameter int SCREEN_W    = DEFAULT_SCREEN_W,
    parameter int SCREEN_H    = DEFAULT_SCREEN_H
) (
    input  logic [WIDTH_BITS-1:0]  x1,
    input  logic [WIDTH_BITS-1:0]  x2,
    input  logic [HEIGHT_BITS-1:0] y1,
    input  logic [HEIGHT_BITS-1:0] y2,
    output logic [WIDTH_BITS-1:0]  xmin,
    output logic [WIDTH_BITS-1:0]  xmax,
    output logic [HEIGHT_BITS-1:0] ymin,
    output logic [HEIGHT_BITS-1:0] ymax,
    output logic                   empty
);

    localparam logic [WIDTH_BITS-1:0]  X_LAST = WIDTH_BITS'(SCREEN_W - 1);
    localparam logic [HEIGHT_BITS-1:0] Y_LAST = HEIGHT_BITS'(SCREEN_H - 1);

    logic [WIDTH_BITS-1:0]  x_hi;
    logic [HEIGHT_BITS-1:0] y_hi;

    always_comb begin
        xmin = (x1 < x2) ? x1 : x2;
        x_hi = (x1 < x2) ? x2 : x1;
        ymin = (y1 < y2) ? y1 : y2;
        y_hi = (y1 < y2) ? y2 : y1;
        // Only the far edge needs clipping; a near edge past the screen means nothing is visible.
        xmax  = (x_hi > X_LAST) ? X_LAST : x_hi;
        ymax  = (y_hi > Y_LAST) ? Y_LAST : y_hi;
        empty = (xmin > X_LAST) || (ymin > Y_LAST);
    end

endmodule

// File: rtl/gpu_rect_raster.sv
// Rectangle rasteriser: latches a command, then streams the covered pixels
// (solid fill or 1-pixel outline) in row-major order over valid/ready.
module gpu_rect_raster
    import gpu_pkg::*;
#(
    parameter int WIDTH_BITS   = 10,
    parameter int HEIGHT_BITS  = 9,
    parameter int SCREEN_W     = DEFAULT_SCREEN_W,
    parameter int SCREEN_H     = DEFAULT_SCREEN_H,
    parameter int CHANNEL_BITS = 8
) (
    input  logic                    clk,
    input  logic                    n_rst,
    input  logic                    start_i,
    input  logic                    abort_i,
    input  logic [WIDTH_BITS-1:0]   x1_i,
    input  logic [WIDTH_BITS-1:0]   x2_i,
    input  logic [HEIGHT_BITS-1:0]  y1_i,
    input  logic [HEIGHT_BITS-1:0]  y2_i,
    input  logic                    mode_i,
    input  logic [CHANNEL_BITS-1:0] r_i,
    input  logic [CHANNEL_BITS-1:0] g_i,
    input  logic [CHANNEL_BITS-1:0] b_i,
    output logic [WIDTH_BITS-1:0]   x_o,
    output logic [HEIGHT_BITS-1:0]  y_o,
    output logic [CHANNEL_BITS-1:0] r_o,
    output logic [CHANNEL_BITS-1:0] g_o,
    output logic [CHANNEL_BITS-1:0] b_o,
    output logic                    valid_o,
    input  logic                    ready_i,
    output logic                    busy_o,
    output logic                    done_o
);

    logic [WIDTH_BITS-1:0]  clip_xmin;
    logic [WIDTH_BITS-1:0]  clip_xmax;
    logic [HEIGHT_BITS-1:0] clip_ymin;
    logic [HEIGHT_BITS-1:0] clip_ymax;
    logic                   clip_empty;

    gpu_rect_clip #(
        .WIDTH_BITS  (WIDTH_BITS),
        .HEIGHT_BITS (HEIGHT_BITS),
        .SCREEN_W    (SCREEN_W),
        .SCREEN_H    (SCREEN_H)
    ) u_clip (
        .x1    (x1_i),
        .x2    (x2_i),
        .y1    (y1_i),
        .y2    (y2_i),
        .xmin  (clip_xmin),
        .xmax  (clip_xmax),
        .ymin  (clip_ymin),
        .ymax  (clip_ymax),
        .empty (clip_empty)
    );

    state_t                  state_reg, state_next;
    logic [WIDTH_BITS-1:0]   x_reg, x_next;
    logic [HEIGHT_BITS-1:0]  y_reg, y_next;
    logic [WIDTH_BITS-1:0]   xmin_reg, xmin_next;
    logic [WIDTH_BITS-1:0]   xmax_reg, xmax_next;
    logic [HEIGHT_BITS-1:0]  ymin_reg, ymin_next;
    logic [HEIGHT_BITS-1:0]  ymax_reg, ymax_next;
    logic                    mode_reg, mode_next;
    logic [CHANNEL_BITS-1:0] r_reg, r_next;
    logic [CHANNEL_BITS-1:0] g_reg, g_next;
    logic [CHANNEL_BITS-1:0] b_reg, b_next;
    logic                    valid_reg, valid_next;
    logic                    busy_reg, busy_next;
    logic                    done_reg, done_next;

    logic at_row_end;
    logic at_last_pixel;
    logic on_interior_row;

    assign at_row_end      = (x_reg == xmax_reg);
    assign at_last_pixel   = at_row_end && (y_reg == ymax_reg);
    assign on_interior_row = (y_reg > ymin_reg) && (y_reg < ymax_reg);

    always_comb begin
        state_next = state_reg;
        x_next     = x_reg;
        y_next     = y_reg;
        xmin_next  = xmin_reg;
        xmax_next  = xmax_reg;
        ymin_next  = ymin_reg;
        ymax_next  = ymax_reg;
        mode_next  = mode_reg;
        r_next     = r_reg;
        g_next     = g_reg;
        b_next     = b_reg;
        valid_next = valid_reg;
        busy_next  = busy_reg;
        done_next  = 1'b0;

        case (state_reg)
            IDLE: begin
                if (start_i) begin
                    xmin_next = clip_xmin;
                    xmax_next = clip_xmax;
                    ymin_next = clip_ymin;
                    ymax_next = clip_ymax;
                    mode_next = mode_i;
                    r_next    = r_i;
                    g_next    = g_i;
                    b_next    = b_i;
                    x_next    = clip_xmin;
                    y_next    = clip_ymin;
                    if (clip_empty) begin
                        state_next = DONE;
                        done_next  = 1'b1;
                    end else begin
                        state_next = RUN;
                        valid_next = 1'b1;
                        busy_next  = 1'b1;
                    end
                end
            end

            RUN: begin
                // Abort wins over a handshake in the same cycle.
                if (abort_i) begin
                    state_next = IDLE;
                    valid_next = 1'b0;
                    busy_next  = 1'b0;
                end else if (ready_i) begin
                    if (at_last_pixel) begin
                        state_next = DONE;
                        valid_next = 1'b0;
                        busy_next  = 1'b0;
                        done_next  = 1'b1;
                    end else if (at_row_end) begin
                        x_next = xmin_reg;
                        y_next = y_reg + HEIGHT_BITS'(1);
                    end else if (mode_reg == MODE_OUTLINE && on_interior_row) begin
                        // Interior outline rows only carry the left and right edge pixels.
                        x_next = xmax_reg;
                    end else begin
                        x_next = x_reg + WIDTH_BITS'(1);
                    end
                end
            end

            DONE: begin
                state_next = IDLE;
            end

            default: begin
                state_next = IDLE;
                valid_next = 1'b0;
                busy_next  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_reg <= IDLE;
            x_reg     <= '0;
            y_reg     <= '0;
            xmin_reg  <= '0;
            xmax_reg  <= '0;
            ymin_reg  <= '0;
            ymax_reg  <= '0;
            mode_reg  <= MODE_FILL;
            r_reg     <= '0;
            g_reg     <= '0;
            b_reg     <= '0;
            valid_reg <= 1'b0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            x_reg     <= x_next;
            y_reg     <= y_next;
            xmin_reg  <= xmin_next;
            xmax_reg  <= xmax_next;
            ymin_reg  <= ymin_next;
            ymax_reg  <= ymax_next;
            mode_reg  <= mode_next;
            r_reg     <= r_next;
            g_reg     <= g_next;
            b_reg     <= b_next;
            valid_reg <= valid_next;
            busy_reg  <= busy_next;
            done_reg  <= done_next;
        end
    end

    assign x_o     = x_reg;
    assign y_o     = y_reg;
    assign r_o     = r_reg;
    assign g_o     = g_reg;
    assign b_o     = b_reg;
    assign valid_o = valid_reg;
    assign busy_o  = busy_reg;
    assign done_o  = done_reg;

endmodule

// File: tb/tb_gpu_rect_raster.sv
// Randomised and directed bench for gpu_rect_raster, checked against a
// set-based model of which pixels a clipped rectangle or outline covers.
module tb_gpu_rect_raster;

    localparam int W  = 10;
    localparam int H  = 9;
    localparam int CB = 8;
    localparam int SW = 640;
    localparam int SH = 480;

    logic          clk = 1'b0;
    logic          n_rst;
    logic          start_i, abort_i, mode_i, ready_i;
    logic [W-1:0]  x1_i, x2_i, x_o;
    logic [H-1:0]  y1_i, y2_i, y_o;
    logic [CB-1:0] r_i, g_i, b_i, r_o, g_o, b_o;
    logic          valid_o, busy_o, done_o;

    gpu_rect_raster #(
        .WIDTH_BITS   (W),
        .HEIGHT_BITS  (H),
        .SCREEN_W     (SW),
        .SCREEN_H     (SH),
        .CHANNEL_BITS (CB)
    ) dut (
        .clk     (clk),
        .n_rst   (n_rst),
        .start_i (start_i),
        .abort_i (abort_i),
        .x1_i    (x1_i),
        .x2_i    (x2_i),
        .y1_i    (y1_i),
        .y2_i    (y2_i),
        .mode_i  (mode_i),
        .r_i     (r_i),
        .g_i     (g_i),
        .b_i     (b_i),
        .x_o     (x_o),
        .y_o     (y_o),
        .r_o     (r_o),
        .g_o     (g_o),
        .b_o     (b_o),
        .valid_o (valid_o),
        .ready_i (ready_i),
        .busy_o  (busy_o),
        .done_o  (done_o)
    );

    always #5 clk = ~clk;

    int tests_run    = 0;
    int tests_failed = 0;

    typedef struct {
        int x;
        int y;
    } pix_t;

    pix_t exp_q[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] expv);
        tests_run++;
        if (got !== expv) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, got, expv);
        end
    endtask

    // Covered pixels: every point of the clipped box (fill) or only its border (outline).
    task automatic build_expected(input int x1, input int x2, input int y1, input int y2,
                                  input bit outline);
        int xmin, xmax, ymin, ymax;
        pix_t p;
        exp_q.delete();
        xmin = (x1 < x2) ? x1 : x2;
        xmax = (x1 < x2) ? x2 : x1;
        ymin = (y1 < y2) ? y1 : y2;
        ymax = (y1 < y2) ? y2 : y1;
        if (xmax > SW - 1) xmax = SW - 1;
        if (ymax > SH - 1) ymax = SH - 1;
        if (xmin > SW - 1 || ymin > SH - 1) return;
        for (int y = ymin; y <= ymax; y++) begin
            for (int x = xmin; x <= xmax; x++) begin
                if (!outline || y == ymin || y == ymax || x == xmin || x == xmax) begin
                    p.x = x;
                    p.y = y;
                    exp_q.push_back(p);
                end
            end
        end
    endtask

    task automatic run_cmd(input int x1, input int x2, input int y1, input int y2,
                           input bit outline, input logic [23:0] rgb,
                           input bit rand_ready, input logic [31:0] stall_mask,
                           input int abort_at, input int rst_at);
        int  idx;
        bit  finished;
        bit  rdy;
        idx      = 0;
        finished = 0;
        build_expected(x1, x2, y1, y2, outline);
        $display("[TB] cmd (%0d,%0d)-(%0d,%0d) mode=%0d pixels=%0d abort_at=%0d rst_at=%0d",
                 x1, y1, x2, y2, outline, exp_q.size(), abort_at, rst_at);
        @(negedge clk);
        x1_i    = W'(x1);
        x2_i    = W'(x2);
        y1_i    = H'(y1);
        y2_i    = H'(y2);
        mode_i  = outline;
        {r_i, g_i, b_i} = rgb;
        ready_i = 1'b0;
        start_i = 1'b1;
        for (int cyc = 1; cyc <= 5000 && !finished; cyc++) begin
            @(negedge clk);
            if (idx == exp_q.size()) begin
                check("done_cycle", {valid_o, busy_o, done_o}, 3'b001);
                start_i  = 1'b0;
                ready_i  = 1'b0;
                finished = 1;
            end else begin
                check("flags_run", {valid_o, busy_o, done_o}, 3'b110);
                check("pix_x", x_o, exp_q[idx].x);
                check("pix_y", y_o, exp_q[idx].y);
                check("colour", {r_o, g_o, b_o}, rgb);
                if (cyc == rst_at) begin
                    n_rst = 1'b0;
                    #1;
                    check("async_reset", {x_o, y_o, r_o, g_o, b_o, valid_o, busy_o, done_o}, 64'd0);
                    @(negedge clk);
                    start_i = 1'b0;
                    ready_i = 1'b0;
                    n_rst   = 1'b1;
                    return;
                end
                if (cyc == abort_at) begin
                    abort_i = 1'b1;
                    ready_i = 1'($urandom);
                    @(negedge clk);
                    abort_i = 1'b0;
                    start_i = 1'b0;
                    check("abort_flags", {valid_o, busy_o, done_o}, 3'b000);
                    @(negedge clk);
                    check("abort_no_done", {valid_o, busy_o, done_o}, 3'b000);
                    return;
                end
                if (rand_ready) rdy = ($urandom_range(0, 3) != 0);
                else            rdy = !(cyc < 32 && stall_mask[cyc]);
                ready_i = rdy;
                if (rdy) idx++;
                // Inputs wander during the command; the latched copy must be used.
                start_i = 1'($urandom);
                x1_i    = W'($urandom);
                x2_i    = W'($urandom);
                y1_i    = H'($urandom);
                y2_i    = H'($urandom);
                mode_i  = 1'($urandom);
                {r_i, g_i, b_i} = 24'($urandom);
            end
        end
        if (!finished) check("timeout", 64'd0, 64'd1);
        @(negedge clk);
        check("done_pulse_end", {valid_o, busy_o, done_o}, 3'b000);
    endtask

    initial begin
        int x1, x2, y1, y2;
        n_rst   = 1'b0;
        start_i = 1'b0;
        abort_i = 1'b0;
        mode_i  = 1'b0;
        ready_i = 1'b0;
        x1_i = '0; x2_i = '0; y1_i = '0; y2_i = '0;
        r_i = '0; g_i = '0; b_i = '0;
        repeat (2) @(negedge clk);
        check("reset_state", {x_o, y_o, r_o, g_o, b_o, valid_o, busy_o, done_o}, 64'd0);
        n_rst = 1'b1;

        run_cmd(2, 4, 3, 4, 0, 24'h123456, 0, 32'h0, 0, 0);
        run_cmd(4, 2, 4, 3, 0, 24'hABCDEF, 0, 32'h0, 0, 0);
        run_cmd(0, 3, 0, 2, 1, 24'h00FF00, 0, 32'h0, 0, 0);
        run_cmd(5, 5, 0, 2, 1, 24'hFF0000, 0, 32'h0, 0, 0);
        run_cmd(630, 700, 470, 500, 0, 24'h0000FF, 0, 32'h0, 0, 0);
        run_cmd(650, 660, 0, 5, 0, 24'h777777, 0, 32'h0, 0, 0);
        run_cmd(0, 3, 0, 0, 0, 24'hC0FFEE, 0, 32'h0000_001C, 0, 0);
        run_cmd(0, 9, 0, 9, 0, 24'h111111, 0, 32'h0, 3, 0);
        run_cmd(1, 3, 1, 2, 0, 24'h222222, 0, 32'h0, 0, 0);
        run_cmd(0, 9, 0, 9, 1, 24'h333333, 0, 32'h0, 0, 4);
        run_cmd(7, 7, 7, 7, 1, 24'h444444, 1, 32'h0, 0, 0);
        run_cmd(0, 0, 2, 8, 0, 24'h555555, 1, 32'h0, 0, 0);

        for (int n = 0; n < 40; n++) begin
            x1 = ($urandom_range(0, 1) != 0) ? int'($urandom_range(620, 660)) : int'($urandom_range(0, 1023));
            y1 = ($urandom_range(0, 1) != 0) ? int'($urandom_range(465, 500)) : int'($urandom_range(0, 511));
            x2 = x1 + int'($urandom_range(0, 24)) - 12;
            y2 = y1 + int'($urandom_range(0, 24)) - 12;
            if (x2 < 0) x2 = 0;
            if (x2 > 1023) x2 = 1023;
            if (y2 < 0) y2 = 0;
            if (y2 > 511) y2 = 511;
            run_cmd(x1, x2, y1, y2, 1'($urandom), 24'($urandom), 1, 32'h0,
                    ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 6)) : 0, 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
